// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// and helpers for access size, alignment and byte-enable generation.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    LD_REQ  = 3'd2,
    LD_RSP  = 3'd3,
    LD_DONE = 3'd4
  } state_e;

  // log2 of the access size in bytes; funct3[1:0] encodes it directly.
  function automatic logic [1:0] size_log2(input logic [2:0] f3);
    return f3[1:0];
  endfunction

  // Low address bits that must be zero for an access of this size.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  // Contiguous byte mask covering one access of this size at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] byte_enable(input logic [1:0] sz, input logic [2:0] lane);
    return size_mask(sz) << lane;
  endfunction

  // D and WU exist only on a 64-bit datapath.
  function automatic logic f3_legal(input logic [2:0] f3, input logic wide);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      F3_D, F3_WU:                    ok = wide;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory port between the load/store unit (master) and memory (slave).
// Handshake: a request transfers in any cycle where mem_req_valid and
// mem_req_ready are both 1; the master holds all mem_req_* stable while
// valid is high and ready is low. mem_rsp_valid is a one-cycle pulse carrying
// read data and has no back-pressure. Writes are posted (no response).
interface lsu_mem_ctrl_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
);
  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic                       mem_req_write;
  logic [DATA_ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0]      mem_req_wdata;
  logic [DATA_WIDTH/8-1:0]    mem_req_be;
  logic                       mem_rsp_valid;
  logic [DATA_WIDTH-1:0]      mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_store_fifo.sv
// Posted-store buffer: synchronous FIFO with full/empty flags.
// Pushes while full and pops while empty are ignored.
module lsu_store_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  // Pointer wrap and occupancy update.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is free.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a ready/valid data-memory port.
// Stores are posted through a small buffer; loads wait for the buffer to
// drain (store->load ordering), then run a request/response sequence with a
// response timeout. The MEM-stage stall is generated here.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int STORE_BUF_DEPTH = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic                       req_valid,
  input  logic                       req_write,
  input  logic [2:0]                 req_funct3,
  input  logic [DATA_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  output logic                       stall,
  output logic                       rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       exc_misalign,
  output logic                       exc_illegal,
  output logic                       bus_err,
  lsu_mem_ctrl_if.master             mem,
  output state_e                     dbg_state
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = DATA_ADDR_WIDTH;
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int EW = AW + NB + DW;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e         state_q, state_d;
  logic [AW-1:0]  ld_addr_q, ld_addr_d;
  logic [2:0]     ld_f3_q, ld_f3_d;
  logic [DW-1:0]  data_q, data_d;
  logic           err_q, err_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           exc_mis_q, exc_mis_d, exc_ill_q, exc_ill_d;

  logic [1:0]     req_sz;
  logic [2:0]     req_lane;
  logic           req_legal, req_misal, req_ok, ld_go, st_push;
  logic [7:0]     req_be8, ld_be8;
  logic [DW-1:0]  req_rep;
  logic [AW-1:0]  req_addr_al;
  logic [EW-1:0]  fifo_head;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [2:0]     ld_lane;
  logic [DW-1:0]  ld_shift, ld_ext;

  assign dbg_state    = state_q;
  assign exc_misalign = exc_mis_q;
  assign exc_illegal  = exc_ill_q;

  // Decode the incoming request: size, lane, legality, alignment, store payload.
  always_comb begin
    req_sz      = size_log2(req_funct3);
    req_lane    = 3'(req_addr[LB-1:0]);
    req_legal   = f3_legal(req_funct3, DW == 64);
    req_misal   = req_legal && ((req_addr[2:0] & align_mask(req_sz)) != 3'b000);
    req_be8     = byte_enable(req_sz, req_lane);
    req_addr_al = {req_addr[AW-1:LB], {LB{1'b0}}};
    case (req_sz)
      2'd0:    req_rep = {NB{req_wdata[7:0]}};
      2'd1:    req_rep = {(NB/2){req_wdata[15:0]}};
      2'd2:    req_rep = {(NB/4){req_wdata[31:0]}};
      default: req_rep = req_wdata;
    endcase
    // Requests are only taken in IDLE; in every other state the presented
    // request is the load already being serviced.
    req_ok    = cpu_rst_n && (state_q == IDLE) && req_valid && req_legal && !req_misal;
    ld_go     = req_ok && !req_write;
    st_push   = req_ok && req_write && !fifo_full;
    exc_ill_d = cpu_rst_n && (state_q == IDLE) && req_valid && !req_legal;
    exc_mis_d = cpu_rst_n && (state_q == IDLE) && req_valid && req_misal;
  end

  lsu_store_fifo #(
    .WIDTH (EW),
    .DEPTH (STORE_BUF_DEPTH)
  ) u_store_fifo (
    .clk       (cpu_clk),
    .rst_n     (cpu_rst_n),
    .push      (st_push),
    .push_data ({req_addr_al, req_be8[NB-1:0], req_rep}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Shift the captured word down to the accessed lane and extend it.
  always_comb begin
    ld_lane  = 3'(ld_addr_q[LB-1:0]);
    ld_be8   = byte_enable(size_log2(ld_f3_q), ld_lane);
    ld_shift = data_q >> {ld_lane, 3'b000};
    case (ld_f3_q)
      F3_B:    ld_ext = DW'($signed(ld_shift[7:0]));
      F3_H:    ld_ext = DW'($signed(ld_shift[15:0]));
      F3_W:    ld_ext = DW'($signed(ld_shift[31:0]));
      F3_BU:   ld_ext = DW'(ld_shift[7:0]);
      F3_HU:   ld_ext = DW'(ld_shift[15:0]);
      F3_WU:   ld_ext = DW'(ld_shift[31:0]);
      default: ld_ext = ld_shift;
    endcase
  end

  // Load FSM next state, stall, response outputs and memory-port muxing.
  always_comb begin
    state_d           = state_q;
    ld_addr_d         = ld_addr_q;
    ld_f3_d           = ld_f3_q;
    data_d            = data_q;
    err_d             = err_q;
    timer_d           = timer_q;
    stall             = 1'b0;
    rsp_valid         = 1'b0;
    rsp_rdata         = '0;
    bus_err           = 1'b0;
    fifo_pop          = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_req_write = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_wdata = '0;
    mem.mem_req_be    = '0;

    // Buffered stores own the port whenever no load transaction is active.
    if ((state_q == IDLE || state_q == DRAIN) && !fifo_empty) begin
      mem.mem_req_valid = 1'b1;
      mem.mem_req_write = 1'b1;
      mem.mem_req_addr  = fifo_head[EW-1 -: AW];
      mem.mem_req_be    = fifo_head[DW +: NB];
      mem.mem_req_wdata = fifo_head[DW-1:0];
      fifo_pop          = mem.mem_req_ready;
    end

    case (state_q)
      IDLE: begin
        if (req_ok && req_write && fifo_full) stall = 1'b1;
        if (ld_go) begin
          stall     = 1'b1;
          ld_addr_d = req_addr;
          ld_f3_d   = req_funct3;
          state_d   = fifo_empty ? LD_REQ : DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (fifo_empty) state_d = LD_REQ;
      end
      LD_REQ: begin
        stall             = 1'b1;
        mem.mem_req_valid = 1'b1;
        mem.mem_req_write = 1'b0;
        mem.mem_req_addr  = {ld_addr_q[AW-1:LB], {LB{1'b0}}};
        mem.mem_req_be    = ld_be8[NB-1:0];
        if (mem.mem_req_ready) begin
          state_d = LD_RSP;
          timer_d = '0;
          err_d   = 1'b0;
        end
      end
      LD_RSP: begin
        stall = 1'b1;
        if (mem.mem_rsp_valid) begin
          data_d  = mem.mem_rsp_rdata;
          state_d = LD_DONE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = LD_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LD_DONE: begin
        rsp_valid = 1'b1;
        bus_err   = err_q;
        rsp_rdata = err_q ? '0 : ld_ext;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and load-context registers; reset abandons any load in flight.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state_q   <= IDLE;
      ld_addr_q <= '0;
      ld_f3_q   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
      exc_mis_q <= 1'b0;
      exc_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      ld_f3_q   <= ld_f3_d;
      data_q    <= data_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      exc_mis_q <= exc_mis_d;
      exc_ill_q <= exc_ill_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl (32-bit datapath, 2-entry store buffer,
// 8-cycle load timeout) with a small memory model on the interface.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          stall, rsp_valid, exc_misalign, exc_illegal, bus_err;
  logic [DW-1:0] rsp_rdata;
  state_e        dbg_state;

  lsu_mem_ctrl_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) mem_if ();

  lsu_mem_ctrl #(
    .DATA_WIDTH      (DW),
    .DATA_ADDR_WIDTH (AW),
    .STORE_BUF_DEPTH (2),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst_n    (cpu_rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .exc_misalign (exc_misalign),
    .exc_illegal  (exc_illegal),
    .bus_err      (bus_err),
    .mem          (mem_if.master),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog.
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;

  // Memory model: logs accepted writes, answers an accepted read one cycle later.
  logic          hs_rd = 1'b0;
  logic          rsp_en = 1'b0;
  logic          inject_rsp = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [3:0]    wr_be_q[$];
  logic [63:0]   exp_q[$];

  always @(negedge cpu_clk) begin
    if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
      if (mem_if.mem_req_write) begin
        wr_addr_q.push_back(mem_if.mem_req_addr);
        wr_data_q.push_back(mem_if.mem_req_wdata);
        wr_be_q.push_back(mem_if.mem_req_be);
      end else begin
        hs_rd = 1'b1;
      end
    end
  end

  always @(posedge cpu_clk) begin
    #2;
    mem_if.mem_rsp_valid = (hs_rd && rsp_en) || inject_rsp;
    mem_if.mem_rsp_rdata = rsp_data;
    hs_rd = 1'b0;
    inject_rsp = 1'b0;
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Load driver: presents a load and records what happens until rsp_valid.
  int            ld_lat, ld_rd_cyc, ld_wr_cyc, ld_stall_n;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] ld_rd_addr;
  logic          ld_err, ld_stall_at;
  state_e        ld_state1;

  task automatic do_load(input logic [2:0] f3, input logic [AW-1:0] addr, input int ready_after);
    bit done = 0;
    int n = 0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = f3; req_addr = addr; req_wdata = '0;
    ld_lat = -1; ld_rd_cyc = -1; ld_wr_cyc = -1; ld_stall_n = 0;
    ld_data = '0; ld_err = 1'b0; ld_stall_at = 1'b1; ld_rd_addr = '0; ld_state1 = IDLE;
    while (!done && n < 40) begin
      if (n == ready_after) mem_if.mem_req_ready = 1'b1;
      @(negedge cpu_clk);
      if (n == 1) ld_state1 = dbg_state;
      if (stall) ld_stall_n++;
      if (mem_if.mem_req_valid && mem_if.mem_req_ready && mem_if.mem_req_write && ld_wr_cyc < 0)
        ld_wr_cyc = n;
      if (mem_if.mem_req_valid && !mem_if.mem_req_write && ld_rd_cyc < 0) begin
        ld_rd_cyc = n;
        ld_rd_addr = mem_if.mem_req_addr;
      end
      if (rsp_valid) begin
        done = 1;
        ld_lat = n;
        ld_data = rsp_rdata;
        ld_err = bus_err;
        ld_stall_at = stall;
      end
      tick();
      n++;
    end
    req_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0;
    repeat (3) tick();
    @(negedge cpu_clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    checks++; if ({exc_misalign, exc_illegal, bus_err} !== 3'b000) begin failures++; $display("FAIL reset_exc: got %b want 000", {exc_misalign, exc_illegal, bus_err}); end
    checks++; if (mem_if.mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid: got %b want 0", mem_if.mem_req_valid); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    tick();
    cpu_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_byte();
    clear_log();
    mem_if.mem_req_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_B; req_addr = 32'h103; req_wdata = 32'h0000_00AB;
    @(negedge cpu_clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_stall: got %b want 0", stall); end
    tick();
    req_valid = 1'b0;
    @(negedge cpu_clk);
    checks++; if ({mem_if.mem_req_valid, mem_if.mem_req_write} !== 2'b11) begin failures++; $display("FAIL sb_req: got valid/write %b want 11", {mem_if.mem_req_valid, mem_if.mem_req_write}); end
    checks++; if (mem_if.mem_req_addr !== 32'h100) begin failures++; $display("FAIL sb_addr: got %h want 00000100", mem_if.mem_req_addr); end
    checks++; if (mem_if.mem_req_be !== 4'b1000) begin failures++; $display("FAIL sb_be: got %b want 1000", mem_if.mem_req_be); end
    checks++; if (mem_if.mem_req_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata: got %h want ababab ab", mem_if.mem_req_wdata); end
    tick();
    mem_if.mem_req_ready = 1'b1;
    tick();
    @(negedge cpu_clk);
    checks++; if (mem_if.mem_req_valid !== 1'b0) begin failures++; $display("FAIL sb_popped: got valid %b want 0", mem_if.mem_req_valid); end
    checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL sb_count: got %0d writes want 1", wr_addr_q.size()); end
    tick();
  endtask

  task automatic test_load_ext();
    clear_log();
    rsp_en = 1'b1;
    rsp_data = 32'h0080_0000;
    do_load(F3_B, 32'h102, 0);
    checks++; if (ld_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data: got %h want ffffff80", ld_data); end
    checks++; if (ld_lat != 3) begin failures++; $display("FAIL lb_latency: got %0d want 3", ld_lat); end
    checks++; if (ld_stall_n != 3 || ld_stall_at !== 1'b0) begin failures++; $display("FAIL lb_stall: got %0d stall cycles (at rsp %b) want 3 (0)", ld_stall_n, ld_stall_at); end
    checks++; if (ld_rd_cyc != 1 || ld_rd_addr !== 32'h100) begin failures++; $display("FAIL lb_rd_req: got cycle %0d addr %h want 1 00000100", ld_rd_cyc, ld_rd_addr); end
    checks++; if (ld_state1 !== LD_REQ) begin failures++; $display("FAIL lb_state: got %0d want %0d", ld_state1, LD_REQ); end
    do_load(F3_BU, 32'h102, 0);
    checks++; if (ld_data !== 32'h0000_0080 || ld_lat != 3) begin failures++; $display("FAIL lbu: got %h lat %0d want 00000080 lat 3", ld_data, ld_lat); end
    rsp_data = 32'h8001_0000;
    do_load(F3_H, 32'h102, 0);
    checks++; if (ld_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data: got %h want ffff8001", ld_data); end
    do_load(F3_HU, 32'h102, 0);
    checks++; if (ld_data !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data: got %h want 00008001", ld_data); end
    rsp_data = 32'h1234_5678;
    do_load(F3_W, 32'h104, 0);
    checks++; if (ld_data !== 32'h1234_5678 || ld_err !== 1'b0) begin failures++; $display("FAIL lw_data: got %h err %b want 12345678 err 0", ld_data, ld_err); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got;
    clear_log();
    mem_if.mem_req_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'h10 + 32'(4 * i);
      req_wdata = 32'h1111_1111 * 32'(i + 1);
      exp_q.push_back({req_addr, req_wdata});
      @(negedge cpu_clk);
      checks++; if (stall !== (i == 2)) begin failures++; $display("FAIL b2b_stall_%0d: got %b want %b", i, stall, i == 2); end
      if (i < 2) tick();
    end
    tick();
    @(negedge cpu_clk);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_held: got %b want 1", stall); end
    tick();
    mem_if.mem_req_ready = 1'b1;
    @(negedge cpu_clk);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_pop_cycle: got %b want 1", stall); end
    tick();
    @(negedge cpu_clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_release: got %b want 0", stall); end
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    checks++; if (wr_addr_q.size() != 3) begin failures++; $display("FAIL b2b_count: got %0d writes want 3", wr_addr_q.size()); end
    while (exp_q.size() > 0 && wr_addr_q.size() > 0) begin
      got = {wr_addr_q.pop_front(), wr_data_q.pop_front()};
      checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL b2b_order: got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_store_load_order();
    clear_log();
    mem_if.mem_req_ready = 1'b0;
    rsp_en = 1'b1;
    rsp_data = 32'hCAFE_F00D;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h200; req_wdata = 32'hDEAD_BEEF;
    @(negedge cpu_clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sl_store_stall: got %b want 0", stall); end
    tick();
    do_load(F3_W, 32'h200, 3);
    checks++; if (ld_state1 !== DRAIN) begin failures++; $display("FAIL sl_drain: got %0d want %0d", ld_state1, DRAIN); end
    checks++; if (ld_wr_cyc != 3 || ld_rd_cyc <= ld_wr_cyc) begin failures++; $display("FAIL sl_order: got write cycle %0d read cycle %0d want write 3 before read", ld_wr_cyc, ld_rd_cyc); end
    checks++; if (ld_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL sl_data: got %h want cafef00d", ld_data); end
    checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h200 || wr_data_q[0] !== 32'hDEAD_BEEF || wr_be_q[0] !== 4'hF) begin
      failures++; $display("FAIL sl_write: got %0d writes, first %h/%h want 1 write 00000200/deadbeef", wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]);
    end
  endtask

  task automatic test_exceptions();
    mem_if.mem_req_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_H; req_addr = 32'h101;
    @(negedge cpu_clk);
    checks++; if ({stall, mem_if.mem_req_valid} !== 2'b00) begin failures++; $display("FAIL mis_present: got stall/valid %b want 00", {stall, mem_if.mem_req_valid}); end
    tick();
    req_valid = 1'b0;
    @(negedge cpu_clk);
    checks++; if ({exc_misalign, exc_illegal, mem_if.mem_req_valid} !== 3'b100) begin failures++; $display("FAIL mis_pulse: got mis/ill/valid %b want 100", {exc_misalign, exc_illegal, mem_if.mem_req_valid}); end
    tick();
    @(negedge cpu_clk);
    checks++; if (exc_misalign !== 1'b0) begin failures++; $display("FAIL mis_width: got %b want 0", exc_misalign); end
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_D; req_addr = 32'h100;
    @(negedge cpu_clk);
    checks++; if ({stall, mem_if.mem_req_valid} !== 2'b00) begin failures++; $display("FAIL ill_present: got stall/valid %b want 00", {stall, mem_if.mem_req_valid}); end
    tick();
    req_valid = 1'b0;
    @(negedge cpu_clk);
    checks++; if ({exc_illegal, exc_misalign} !== 2'b10) begin failures++; $display("FAIL ill_pulse: got ill/mis %b want 10", {exc_illegal, exc_misalign}); end
    tick();
    @(negedge cpu_clk);
    checks++; if (exc_illegal !== 1'b0) begin failures++; $display("FAIL ill_width: got %b want 0", exc_illegal); end
    tick();
  endtask

  task automatic test_timeout();
    rsp_en = 1'b0;
    do_load(F3_W, 32'h40, 0);
    checks++; if (ld_lat != 10 || ld_err !== 1'b1) begin failures++; $display("FAIL to_rsp: got lat %0d err %b want lat 10 err 1", ld_lat, ld_err); end
    checks++; if (ld_data !== 32'h0) begin failures++; $display("FAIL to_data: got %h want 0", ld_data); end
    checks++; if (ld_stall_n != 10) begin failures++; $display("FAIL to_stall: got %0d stall cycles want 10", ld_stall_n); end
    @(negedge cpu_clk);
    checks++; if ({bus_err, rsp_valid} !== 2'b00) begin failures++; $display("FAIL to_pulse: got err/valid %b want 00", {bus_err, rsp_valid}); end
    tick();
  endtask

  task automatic test_reset_mid_load();
    rsp_en = 1'b0;
    mem_if.mem_req_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h300;
    repeat (3) tick();
    @(negedge cpu_clk);
    checks++; if (dbg_state !== LD_RSP || stall !== 1'b1) begin failures++; $display("FAIL rm_in_rsp: got state %0d stall %b want %0d 1", dbg_state, stall, LD_RSP); end
    tick();
    cpu_rst_n = 1'b0;
    req_valid = 1'b0;
    tick();
    @(negedge cpu_clk);
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rm_state: got %0d want %0d", dbg_state, IDLE); end
    checks++; if ({stall, rsp_valid, bus_err, exc_misalign, exc_illegal, mem_if.mem_req_valid} !== 6'b0) begin
      failures++; $display("FAIL rm_outputs: got %b want 000000", {stall, rsp_valid, bus_err, exc_misalign, exc_illegal, mem_if.mem_req_valid});
    end
    tick();
    cpu_rst_n = 1'b1;
    inject_rsp = 1'b1;
    @(negedge cpu_clk);
    checks++; if ({rsp_valid, dbg_state} !== {1'b0, IDLE}) begin failures++; $display("FAIL rm_late_rsp: got valid %b state %0d want 0 %0d", rsp_valid, dbg_state, IDLE); end
    tick();
    @(negedge cpu_clk);
    checks++; if (rsp_valid !== 1'b0 || dbg_state !== IDLE) begin failures++; $display("FAIL rm_after: got valid %b state %0d want 0 %0d", rsp_valid, dbg_state, IDLE); end
    tick();
  endtask

  initial begin
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = '0;
    test_reset();
    test_store_byte();
    test_load_ext();
    test_back_to_back();
    test_store_load_order();
    test_exceptions();
    test_timeout();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised load/store unit between the MEM stage of the pipelined CPU and a ready/valid data-memory port.
- Handles byte/half/word loads and stores (doubleword when DATA_WIDTH=64), with lane alignment, byte enables and sign/zero extension.
- Posts stores through a STORE_BUF_DEPTH-entry buffer and generates the MEM-stage stall, replacing the external data_mem_hazard input.
- Flags misaligned and illegal accesses, and bus timeouts.

Parameters:
- DATA_WIDTH, 32, data/lane width; legal values are 32 or 64.
- DATA_ADDR_WIDTH, 32, byte address width.
- STORE_BUF_DEPTH, 2, posted-store entries; must be a power of two and ≥1.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting in LD_RSP before a bus error is raised.

Ports:
- cpu_clk  in  1  clock.
- cpu_rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  MEM-stage load/store request. Held stable while stall=1.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign code.
- req_addr  in  DATA_ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- stall  out  1  freeze PC..MEM stages this cycle.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid.
- rsp_rdata  out  DATA_WIDTH  extended load result.
- exc_misalign  out  1  one-cycle pulse, misaligned access.
- exc_illegal  out  1  one-cycle pulse, illegal funct3 for this width.
- bus_err  out  1  one-cycle pulse, load timed out.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_write  out  1  request is a write.
- mem_req_addr  out  DATA_ADDR_WIDTH  lane-aligned address; low log2(DATA_WIDTH/8) bits are 0.
- mem_req_wdata  out  DATA_WIDTH  lane-replicated write data.
- mem_req_be  out  DATA_WIDTH/8  byte enables.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset (cpu_rst_n=0 at a clock edge):
  - All outputs go to 0; FSM goes to IDLE.
  - Store buffer is emptied and the timeout counter cleared.
  - An in-flight load or pending store is discarded; a late mem_rsp_valid is ignored until the next LD_RSP.
- funct3 decoding:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU are always legal.
  - 011 D and 110 WU are legal only when DATA_WIDTH=64.
  - All other codes raise exc_illegal.
- Misalignment: an access is misaligned when addr mod size ≠ 0. It raises exc_misalign.
- Illegal or misaligned request: exception pulses in the cycle after the request is presented; no memory access; stall=0.
- Store path:
  - If the buffer is not full: enqueue {addr, be, replicated data}; stall=0 in the same cycle.
  - If the buffer is full: stall=1. An enqueue is never accepted in a cycle in which the buffer is full, even if a dequeue occurs in that cycle.
- Drain:
  - When the buffer is non-empty and the FSM is IDLE or DRAIN, the head entry drives the mem_req_* outputs with mem_req_valid=1.
  - The entry is popped on mem_req_ready. Writes are posted; no response is expected.
- Load FSM:
  - IDLE: a legal load sets stall=1. Go to DRAIN if the buffer is non-empty, else LD_REQ.
  - DRAIN: wait for the buffer to become empty, then go to LD_REQ. This keeps store→load ordering.
  - LD_REQ: mem_req_valid=1, mem_req_write=0. On mem_req_ready, go to LD_RSP and clear the timer.
  - LD_RSP: on mem_rsp_valid, capture the data and go to LD_DONE. If the timer reaches TIMEOUT_CYCLES, go to LD_DONE with error set.
  - LD_DONE: rsp_valid=1, stall=0, bus_err=error flag, rsp_rdata = 0 on error else extended lane data. Return to IDLE.
  - stall=1 in every load-FSM cycle from IDLE-accept through LD_RSP.
- Latency: a load with an empty buffer and zero-wait memory has rsp_valid 3 cycles after the request is first presented.
- Lane and extension rules:
  - lane = addr[log2(DATA_WIDTH/8)-1:0].
  - be = size mask << lane.
  - wdata = the low `size` bytes of req_wdata, replicated across lanes.
  - Load data = rdata >> (8*lane), then sign- or zero-extended from the access size.
- A mem_rsp_valid arriving outside LD_RSP is ignored.

Decomposition:
- Package lsu_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - FSM state enum: IDLE, DRAIN, LD_REQ, LD_RSP, LD_DONE.
  - Size-from-funct3 and byte-enable helper functions.
- Sub-module lsu_store_fifo: parametrised synchronous FIFO with full/empty flags, an entry width of DATA_ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8, and synchronous active-low reset.

Test Plan:
- SB addr 0x103, wdata 0xAB, DATA_WIDTH=32 → mem_req_addr 0x100, be 4'b1000, wdata 0xABABABAB; stall stays 0.
- LB addr 0x102, memory returns 0x0080_0000 → rsp_rdata 0xFFFFFF80. LBU of the same → 0x00000080. rsp_valid 3 cycles after the request when ready is always 1.
- Three back-to-back SW with STORE_BUF_DEPTH=2 and mem_req_ready=0 → 3rd store sees stall=1 until the first pop; memory receives writes in program order.
- SW 0x200 then LW 0x200 → load held in DRAIN until the write is accepted; mem_req_write=0 is issued only after that.
- LH addr 0x101 → exc_misalign pulse, no mem_req_valid, stall 0. funct3=011 at DATA_WIDTH=32 → exc_illegal pulse.
- LW with mem_rsp_valid never asserted, TIMEOUT_CYCLES=8 → bus_err and rsp_valid pulse with rdata 0. A reset asserted mid-LD_RSP returns the FSM to IDLE with all outputs 0.
